// File: rtl/io_select_sequencer.sv
// io_select_sequencer
//
// Shares a 74LS138-style 3-to-8 I/O device-select decoder between two bus
// requesters (0 = CPU I/O path, 1 = cassette/sound DMA path). Each granted
// access runs SETUP -> STROBE -> HOLD. The select code is stable for the
// whole access, so exactly one active-low decoder output pulses, and only
// while dec_g2an is low in STROBE. All outputs come straight from flops,
// so none of them can glitch.
//
// Parameters (0 is treated as 1, values above 15 are clamped to 15):
//   SETUP_CYCLES  : cycles the code is stable before the strobe (default 1)
//   STROBE_CYCLES : cycles the decoder is enabled (default 2)
//   HOLD_CYCLES   : cycles the code is held after the strobe (default 1)
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req0/sel0/ack0       : requester 0 level request, device code, done pulse
//   req1/sel1/ack1       : requester 1 level request, device code, done pulse
//   dec_a/dec_b/dec_c    : decoder select code, bits 0/1/2 of the latched sel
//   dec_g1               : decoder active-high enable (access window)
//   dec_g2an             : decoder active-low enable A (strobe)
//   dec_g2bn             : decoder active-low enable B (access window)
//   busy                 : high whenever an access is in progress
//   grant                : owner of the current or most recent access
//
// Build option:
//   IO_SEQ_ROUND_ROBIN_EN : when defined, simultaneous requests alternate
//                           between requesters; otherwise req0 always wins.

module io_select_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [2:0] sel0,
  output logic       ack0,
  input  logic       req1,
  input  logic [2:0] sel1,
  output logic       ack1,
  output logic       dec_a,
  output logic       dec_b,
  output logic       dec_c,
  output logic       dec_g1,
  output logic       dec_g2an,
  output logic       dec_g2bn,
  output logic       busy,
  output logic       grant
);

  function automatic logic [3:0] phase_len(input int v);
    if (v <= 1) begin
      return 4'd1;
    end else if (v >= 15) begin
      return 4'd15;
    end else begin
      return 4'(v);
    end
  endfunction

  localparam logic [3:0] SETUP_LEN  = phase_len(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LEN = phase_len(STROBE_CYCLES);
  localparam logic [3:0] HOLD_LEN   = phase_len(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [2:0] code_reg, code_next;
  logic       grant_reg, grant_next;
  logic       ack0_reg, ack0_next;
  logic       ack1_reg, ack1_next;
  logic       busy_reg, busy_next;
  logic       g1_reg, g1_next;
  logic       g2an_reg, g2an_next;
  logic       g2bn_reg, g2bn_next;
  logic       winner;
  logic       ack_fire;

`ifdef IO_SEQ_ROUND_ROBIN_EN
  // Remembers the most recently granted requester. Resets to 1 so that
  // requester 0 wins the first contested arbitration.
  logic       last_reg, last_next;

  always_comb begin
    if (req0 && req1) begin
      winner = ~last_reg;
    end else begin
      winner = req1 & ~req0;
    end
  end
`else
  always_comb begin
    winner = ~req0;
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    grant_next = grant_reg;
`ifdef IO_SEQ_ROUND_ROBIN_EN
    last_next  = last_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          state_next = SETUP;
          cnt_next   = SETUP_LEN;
          code_next  = winner ? sel1 : sel0;
          grant_next = winner;
`ifdef IO_SEQ_ROUND_ROBIN_EN
          last_next  = winner;
`endif
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd1) begin
          state_next = STROBE;
          cnt_next   = STROBE_LEN;
        end else begin
          cnt_next   = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 4'd1) begin
          state_next = HOLD;
          cnt_next   = HOLD_LEN;
        end else begin
          cnt_next   = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd1) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next   = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each
    // output flop already holds the value belonging to the cycle it is in.
    // The ack lands in the final HOLD cycle: HOLD with one count left.
    ack_fire  = (state_next == HOLD) && (cnt_next == 4'd1);
    ack0_next = ack_fire & ~grant_next;
    ack1_next = ack_fire & grant_next;
    busy_next = (state_next != IDLE);
    g1_next   = (state_next != IDLE);
    g2bn_next = (state_next == IDLE);
    g2an_next = (state_next != STROBE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      code_reg  <= 3'd0;
      grant_reg <= 1'b0;
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      g1_reg    <= 1'b0;
      g2an_reg  <= 1'b1;
      g2bn_reg  <= 1'b1;
`ifdef IO_SEQ_ROUND_ROBIN_EN
      last_reg  <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      grant_reg <= grant_next;
      ack0_reg  <= ack0_next;
      ack1_reg  <= ack1_next;
      busy_reg  <= busy_next;
      g1_reg    <= g1_next;
      g2an_reg  <= g2an_next;
      g2bn_reg  <= g2bn_next;
`ifdef IO_SEQ_ROUND_ROBIN_EN
      last_reg  <= last_next;
`endif
    end
  end

  assign dec_a    = code_reg[0];
  assign dec_b    = code_reg[1];
  assign dec_c    = code_reg[2];
  assign dec_g1   = g1_reg;
  assign dec_g2an = g2an_reg;
  assign dec_g2bn = g2bn_reg;
  assign ack0     = ack0_reg;
  assign ack1     = ack1_reg;
  assign busy     = busy_reg;
  assign grant    = grant_reg;

endmodule

// File: tb/tb_io_select_sequencer.sv
// Testbench for io_select_sequencer. Three instances share one set of
// requester inputs: instance 0 uses the default phase lengths, instance 1
// uses S=3/T=1/H=2, instance 2 uses S=T=H=0 (behaves as 1/1/1).
// Observed outputs per instance are packed as
//   {busy, g1, g2an, g2bn, code[2:0], ack0, ack1, grant}.

module tb_io_select_sequencer;

  localparam int PS [3] = '{1, 3, 0};
  localparam int PT [3] = '{2, 1, 0};
  localparam int PH [3] = '{1, 2, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [2:0] sel0 = 3'd0;
  logic [2:0] sel1 = 3'd0;

  logic o_ack0 [3];
  logic o_ack1 [3];
  logic o_a    [3];
  logic o_b    [3];
  logic o_c    [3];
  logic o_g1   [3];
  logic o_g2an [3];
  logic o_g2bn [3];
  logic o_busy [3];
  logic o_grant[3];
  logic [9:0] obs [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      io_select_sequencer #(
        .SETUP_CYCLES (PS[gi]),
        .STROBE_CYCLES(PT[gi]),
        .HOLD_CYCLES  (PH[gi])
      ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .sel0    (sel0),
        .ack0    (o_ack0[gi]),
        .req1    (req1),
        .sel1    (sel1),
        .ack1    (o_ack1[gi]),
        .dec_a   (o_a[gi]),
        .dec_b   (o_b[gi]),
        .dec_c   (o_c[gi]),
        .dec_g1  (o_g1[gi]),
        .dec_g2an(o_g2an[gi]),
        .dec_g2bn(o_g2bn[gi]),
        .busy    (o_busy[gi]),
        .grant   (o_grant[gi])
      );
      assign obs[gi] = {o_busy[gi], o_g1[gi], o_g2an[gi], o_g2bn[gi],
                        o_c[gi], o_b[gi], o_a[gi],
                        o_ack0[gi], o_ack1[gi], o_grant[gi]};
    end
  endgenerate

  function automatic logic [9:0] mk(bit b, bit g1, bit g2a, bit g2b,
                                    logic [2:0] c, bit a0, bit a1, bit gr);
    return {b, g1, g2a, g2b, c, a0, a1, gr};
  endfunction

  function automatic logic [9:0] st_idle(logic [2:0] c, bit gr);
    return mk(1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0, gr);
  endfunction
  function automatic logic [9:0] st_setup(logic [2:0] c, bit gr);
    return mk(1'b1, 1'b1, 1'b1, 1'b0, c, 1'b0, 1'b0, gr);
  endfunction
  function automatic logic [9:0] st_strobe(logic [2:0] c, bit gr);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, c, 1'b0, 1'b0, gr);
  endfunction
  function automatic logic [9:0] st_hold(logic [2:0] c, bit gr, bit ack);
    return mk(1'b1, 1'b1, 1'b1, 1'b0, c, ack & ~gr, ack & gr, gr);
  endfunction

  task automatic check(string name, logic [9:0] got, logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    sel0 = 3'd0;
    sel1 = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit         rst;
    int         inst;
    bit         r0;
    logic [2:0] s0;
    bit         r1;
    logic [2:0] s1;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit rst, int inst, bit r0, logic [2:0] s0, bit r1,
                     logic [2:0] s1, logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.inst = inst; v.r0 = r0; v.s0 = s0;
    v.r1 = r1; v.s1 = s1; v.exp = exp;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  // The model tracks only how far into the access we are (1..S+T+H);
  // phase and outputs follow from that position with plain arithmetic.
  int         m_t;
  logic [2:0] m_code;
  bit         m_grant;
  bit         m_last;

  function automatic int eff(int v);
    return (v < 1) ? 1 : ((v > 15) ? 15 : v);
  endfunction

  task automatic model_reset();
    m_t = 0; m_code = 3'd0; m_grant = 1'b0; m_last = 1'b1;
  endtask

  task automatic model_step(int inst);
    int len;
    bit w;
    len = eff(PS[inst]) + eff(PT[inst]) + eff(PH[inst]);
    if (reset) begin
      model_reset();
    end else if (m_t == 0) begin
      if (req0 || req1) begin
`ifdef IO_SEQ_ROUND_ROBIN_EN
        if (req0 && req1) w = ~m_last;
        else w = req1;
`else
        w = !req0;
`endif
        m_grant = w;
        m_last  = w;
        m_code  = w ? sel1 : sel0;
        m_t     = 1;
      end
    end else if (m_t == len) begin
      m_t = 0;
    end else begin
      m_t = m_t + 1;
    end
  endtask

  function automatic logic [9:0] model_exp(int inst);
    int s, t, len;
    bit act, strobe, ack;
    s = eff(PS[inst]);
    t = eff(PT[inst]);
    len = s + t + eff(PH[inst]);
    act = (m_t != 0);
    strobe = (m_t > s) && (m_t <= s + t);
    ack = (m_t == len);
    return mk(act, act, ~strobe, ~act, m_code,
              ack & ~m_grant, ack & m_grant, m_grant);
  endfunction

  // ---------------- test sequence ----------------
  int         n_ack;
  int         order [3];
  int         exp_order [3];
  bit         pend0, pend1;
  logic [9:0] mexp;

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state_%0d", i), obs[i], st_idle(3'd0, 1'b0));
    end

    // single access, defaults, req0 sel0=5
    add(1, 0, 1, 3'd5, 0, 3'd0, st_idle(3'd0, 0));
    add(0, 0, 1, 3'd5, 0, 3'd0, st_setup(3'd5, 0));
    add(0, 0, 1, 3'd5, 0, 3'd0, st_strobe(3'd5, 0));
    add(0, 0, 1, 3'd5, 0, 3'd0, st_strobe(3'd5, 0));
    add(0, 0, 1, 3'd5, 0, 3'd0, st_hold(3'd5, 0, 1));
    add(0, 0, 0, 3'd5, 0, 3'd0, st_idle(3'd5, 0));
    add(0, 0, 0, 3'd5, 0, 3'd0, st_idle(3'd5, 0));
    // S=3 T=1 H=2, req1 sel1=0
    add(1, 1, 0, 3'd0, 1, 3'd0, st_idle(3'd0, 0));
    add(0, 1, 0, 3'd0, 1, 3'd0, st_setup(3'd0, 1));
    add(0, 1, 0, 3'd0, 1, 3'd0, st_setup(3'd0, 1));
    add(0, 1, 0, 3'd0, 1, 3'd0, st_setup(3'd0, 1));
    add(0, 1, 0, 3'd0, 1, 3'd0, st_strobe(3'd0, 1));
    add(0, 1, 0, 3'd0, 1, 3'd0, st_hold(3'd0, 1, 0));
    add(0, 1, 0, 3'd0, 1, 3'd0, st_hold(3'd0, 1, 1));
    add(0, 1, 0, 3'd0, 0, 3'd0, st_idle(3'd0, 1));
    // S=T=H=0 behaves as 1/1/1, req0 sel0=3
    add(1, 2, 1, 3'd3, 0, 3'd0, st_idle(3'd0, 0));
    add(0, 2, 1, 3'd3, 0, 3'd0, st_setup(3'd3, 0));
    add(0, 2, 1, 3'd3, 0, 3'd0, st_strobe(3'd3, 0));
    add(0, 2, 1, 3'd3, 0, 3'd0, st_hold(3'd3, 0, 1));
    add(0, 2, 0, 3'd3, 0, 3'd0, st_idle(3'd3, 0));
    // sel0 changes 2 -> 7 during STROBE; latched code must stay 2
    add(1, 0, 1, 3'd2, 0, 3'd0, st_idle(3'd0, 0));
    add(0, 0, 1, 3'd2, 0, 3'd0, st_setup(3'd2, 0));
    add(0, 0, 1, 3'd7, 0, 3'd0, st_strobe(3'd2, 0));
    add(0, 0, 1, 3'd7, 0, 3'd0, st_strobe(3'd2, 0));
    add(0, 0, 1, 3'd7, 0, 3'd0, st_hold(3'd2, 0, 1));
    add(0, 0, 0, 3'd7, 0, 3'd0, st_idle(3'd2, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        @(posedge clk);
        #1;
      end
      req0 = tbl[i].r0; sel0 = tbl[i].s0;
      req1 = tbl[i].r1; sel1 = tbl[i].s1;
      @(negedge clk);
      check($sformatf("vec%0d_inst%0d", i, tbl[i].inst), obs[tbl[i].inst], tbl[i].exp);
    end

    // reset asserted during STROBE
    do_reset();
    req0 = 1'b1; sel0 = 3'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_pre_strobe", obs[0], st_strobe(3'd4, 0));
    reset = 1'b1;
    req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_after_edge", obs[0], st_idle(3'd0, 0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_mid_no_ack", obs[0], st_idle(3'd0, 0));
    end

    // both requesters held high for three accesses
`ifdef IO_SEQ_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0};
`else
    exp_order = '{0, 0, 0};
`endif
    do_reset();
    req0 = 1'b1; sel0 = 3'd1; req1 = 1'b1; sel1 = 3'd6;
    n_ack = 0;
    order = '{2, 2, 2};
    for (int c = 0; c < 40 && n_ack < 3; c++) begin
      @(negedge clk);
      check("arb_one_ack", 10'(obs[0][2] & obs[0][1]), 10'd0);
      if (obs[0][2] || obs[0][1]) begin
        order[n_ack] = obs[0][1] ? 1 : 0;
        check("arb_code", 10'(obs[0][5:3]), obs[0][1] ? 10'd6 : 10'd1);
        n_ack++;
      end
    end
    check("arb_ack_count", 10'(n_ack), 10'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("arb_order_%0d", k), 10'(order[k]), 10'(exp_order[k]));
    end
    req0 = 1'b0; req1 = 1'b0;

    // randomized traffic against the reference model, each instance in turn
    for (int inst = 0; inst < 3; inst++) begin
      do_reset();
      model_reset();
      pend0 = 1'b0; pend1 = 1'b0;
      mexp = model_exp(inst);
      for (int cyc = 0; cyc < 300; cyc++) begin
        if ($urandom_range(0, 59) == 0) begin
          reset = 1'b1;
          req0 = 1'b0; req1 = 1'b0;
          pend0 = 1'b0; pend1 = 1'b0;
        end else begin
          reset = 1'b0;
          if (mexp[2]) begin
            req0 = 1'b0; pend0 = 1'b0;
          end else if (!pend0) begin
            if ($urandom_range(0, 2) == 0) begin
              req0 = 1'b1; sel0 = 3'($urandom_range(0, 7)); pend0 = 1'b1;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            sel0 = 3'($urandom_range(0, 7));
          end
          if (mexp[1]) begin
            req1 = 1'b0; pend1 = 1'b0;
          end else if (!pend1) begin
            if ($urandom_range(0, 2) == 0) begin
              req1 = 1'b1; sel1 = 3'($urandom_range(0, 7)); pend1 = 1'b1;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            sel1 = 3'($urandom_range(0, 7));
          end
        end
        @(negedge clk);
        mexp = model_exp(inst);
        check($sformatf("rand_inst%0d_cyc%0d", inst, cyc), obs[inst], mexp);
        @(posedge clk);
        model_step(inst);
        mexp = model_exp(inst);
        #1;
      end
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
